// File: rtl/jump_resolve_unit_pkg.sv
// Shared constants for the branch/jump resolution unit: datapath width,
// link increment and the comparison-select encoding.
package jump_resolve_unit_pkg;

    localparam int WIDTH   = 32;
    localparam int PC_INCR = 4;

    localparam logic [2:0] CMP_NONE = 3'b000;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NE   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b011;
    localparam logic [2:0] CMP_LTU  = 3'b100;
    localparam logic [2:0] CMP_GE   = 3'b101;
    localparam logic [2:0] CMP_GEU  = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/jump_resolve_unit_cmp_unit.sv
// Combinational branch comparator: evaluates the condition selected by
// cmp_ctrl on two operands; reserved and "none" encodings yield 0.
module cmp_unit
    import jump_resolve_unit_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [2:0]   cmp_ctrl,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         res
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (op_a == op_b);
    assign lt_s = ($signed(op_a) < $signed(op_b));
    assign lt_u = (op_a < op_b);

    always_comb begin
        res = 1'b0;
        case (cmp_ctrl)
            CMP_EQ:  res = eq;
            CMP_NE:  res = ~eq;
            CMP_LT:  res = lt_s;
            CMP_LTU: res = lt_u;
            CMP_GE:  res = ~lt_s;
            CMP_GEU: res = ~lt_u;
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/jump_resolve_unit.sv
// Branch/jump resolution unit: captures operands on EN, then presents target,
// link address and branch condition. Optional macro JALR_LSB_CLEAR_EN clears
// bit 0 of JALR targets.
module jump_resolve_unit
    import jump_resolve_unit_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         EN,
    input  logic         JALR,
    input  logic [2:0]   cmp_ctrl,
    input  logic [W-1:0] rs1_data,
    input  logic [W-1:0] rs2_data,
    input  logic [W-1:0] imm,
    input  logic [W-1:0] PC,
    output logic [W-1:0] PC_jump,
    output logic [W-1:0] PC_wb,
    output logic         cmp_res,
    output logic         busy
);

    state_t       state_reg;
    state_t       state_next;
    logic         capture;

    logic         jalr_reg;
    logic [2:0]   cmp_ctrl_reg;
    logic [W-1:0] rs1_reg;
    logic [W-1:0] rs2_reg;
    logic [W-1:0] imm_reg;
    logic [W-1:0] pc_reg;

    logic [W-1:0] target_base;
    logic [W-1:0] target_sum;

    // EN seen while holding is dropped, so issue is accepted every other cycle.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (EN) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            jalr_reg     <= 1'b0;
            cmp_ctrl_reg <= CMP_NONE;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            imm_reg      <= '0;
            pc_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                jalr_reg     <= JALR;
                cmp_ctrl_reg <= cmp_ctrl;
                rs1_reg      <= rs1_data;
                rs2_reg      <= rs2_data;
                imm_reg      <= imm;
                pc_reg       <= PC;
            end
        end
    end

    assign target_base = jalr_reg ? rs1_reg : pc_reg;
    assign target_sum  = target_base + imm_reg;

`ifdef JALR_LSB_CLEAR_EN
    assign PC_jump = jalr_reg ? {target_sum[W-1:1], 1'b0} : target_sum;
`else
    assign PC_jump = target_sum;
`endif

    assign PC_wb = pc_reg + W'(PC_INCR);
    assign busy  = (state_reg == HOLD);

    cmp_unit #(
        .W(W)
    ) u_cmp (
        .cmp_ctrl(cmp_ctrl_reg),
        .op_a    (rs1_reg),
        .op_b    (rs2_reg),
        .res     (cmp_res)
    );

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Self-checking bench for jump_resolve_unit: directed cases then random
// traffic against a behavioural model.
module tb_jump_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EN;
    logic        JALR;
    logic [2:0]  cmp_ctrl;
    logic [31:0] rs1_data, rs2_data, imm, PC;
    logic [31:0] PC_jump, PC_wb;
    logic        cmp_res, busy;

    int errors = 0;
    int checks = 0;

    // Model of the captured operation.
    logic        m_busy;
    logic        m_jalr;
    logic [2:0]  m_ctrl;
    logic [31:0] m_rs1, m_rs2, m_imm, m_pc;

    jump_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .JALR(JALR), .cmp_ctrl(cmp_ctrl),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .PC(PC),
        .PC_jump(PC_jump), .PC_wb(PC_wb), .cmp_res(cmp_res), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_jump();
        longint unsigned s;
        logic [31:0] r;
        s = (m_jalr ? longint'(m_rs1) : longint'(m_pc)) + longint'(m_imm);
        r = s[31:0];
`ifdef JALR_LSB_CLEAR_EN
        if (m_jalr) r = r & 32'hFFFF_FFFE;
`endif
        return r;
    endfunction

    function automatic logic [31:0] exp_wb();
        longint unsigned s;
        s = longint'(m_pc) + 4;
        return s[31:0];
    endfunction

    function automatic logic exp_cmp();
        longint sa, sb;
        sa = (m_rs1 >= 32'h8000_0000) ? longint'(m_rs1) - 64'sh1_0000_0000 : longint'(m_rs1);
        sb = (m_rs2 >= 32'h8000_0000) ? longint'(m_rs2) - 64'sh1_0000_0000 : longint'(m_rs2);
        case (m_ctrl)
            3'd1: return m_rs1 == m_rs2;
            3'd2: return m_rs1 != m_rs2;
            3'd3: return sa < sb;
            3'd4: return m_rs1 < m_rs2;
            3'd5: return sa >= sb;
            3'd6: return m_rs1 >= m_rs2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic drive(input logic en, input logic jalr, input logic [2:0] ctrl,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] pc);
        EN = en; JALR = jalr; cmp_ctrl = ctrl;
        rs1_data = r1; rs2_data = r2; imm = im; PC = pc;
    endtask

    // One clock: advance the model from the sampled inputs, then check all outputs.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_jalr = 1'b0; m_ctrl = 3'd0;
            m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (EN) begin
            m_busy = 1'b1; m_jalr = JALR; m_ctrl = cmp_ctrl;
            m_rs1 = rs1_data; m_rs2 = rs2_data; m_imm = imm; m_pc = PC;
        end
        #1;
        chk({tag, "_busy"}, {31'b0, busy}, {31'b0, m_busy});
        chk({tag, "_jump"}, PC_jump, exp_jump());
        chk({tag, "_wb"}, PC_wb, exp_wb());
        chk({tag, "_cmp"}, {31'b0, cmp_res}, {31'b0, exp_cmp()});
        $display("%s rst_n=%0b en=%0b busy=%0b jump=%h wb=%h cmp=%0b",
                 tag, rst_n, EN, busy, PC_jump, PC_wb, cmp_res);
    endtask

    initial begin
        logic [2:0] ctrls [4];
        logic       cexp  [4];
        logic [31:0] jalr_exp;
        ctrls = '{3'd3, 3'd4, 3'd6, 3'd7};
        cexp  = '{1'b1, 1'b0, 1'b1, 1'b0};

        m_busy = 1'b0; m_jalr = 1'b0; m_ctrl = 3'd0;
        m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3'd1, 32'h1234, 32'h1234, 32'h55, 32'h800);

        // Reset, with EN asserted to confirm reset priority.
        tick("reset0");
        tick("reset1");
        chk("reset_wb_const", PC_wb, 32'h4);
        chk("reset_jump_const", PC_jump, 32'h0);
        chk("reset_busy_const", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;

        // Branch with a negative offset.
        drive(1'b1, 1'b0, 3'd1, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h100);
        tick("branch");
        chk("branch_jump_const", PC_jump, 32'hF0);
        chk("branch_wb_const", PC_wb, 32'h104);
        chk("branch_cmp_const", {31'b0, cmp_res}, 32'h1);
        drive(1'b0, 1'b0, 3'd0, 0, 0, 0, 0);
        tick("branch_idle");

        // Signed versus unsigned compares on a negative operand.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, ctrls[i], 32'h8000_0000, 32'h1, 32'h0, 32'h0);
            tick("cmp");
            chk("cmp_const", {31'b0, cmp_res}, {31'b0, cexp[i]});
            drive(1'b0, 1'b0, 3'd0, 0, 0, 0, 0);
            tick("cmp_idle");
        end

        // JALR target with an odd base.
        drive(1'b1, 1'b1, 3'd0, 32'h2003, 32'h0, 32'h4, 32'h40);
        tick("jalr");
`ifdef JALR_LSB_CLEAR_EN
        jalr_exp = 32'h2006;
`else
        jalr_exp = 32'h2007;
`endif
        chk("jalr_jump_const", PC_jump, jalr_exp);
        chk("jalr_wb_const", PC_wb, 32'h44);
        drive(1'b0, 1'b0, 3'd0, 0, 0, 0, 0);
        tick("jalr_idle");

        // Back-to-back EN: A captured, B dropped, C captured.
        drive(1'b1, 1'b0, 3'd2, 32'd1, 32'd2, 32'h10, 32'h1000);
        tick("b2b_a");
        drive(1'b1, 1'b1, 3'd1, 32'h3000, 32'h3000, 32'h20, 32'h2000);
        tick("b2b_b");
        chk("b2b_b_busy_const", {31'b0, busy}, 32'h0);
        chk("b2b_b_wb_const", PC_wb, 32'h1004);
        drive(1'b1, 1'b0, 3'd5, 32'd7, 32'd3, 32'h30, 32'h3000);
        tick("b2b_c");
        chk("b2b_c_busy_const", {31'b0, busy}, 32'h1);
        chk("b2b_c_wb_const", PC_wb, 32'h3004);
        drive(1'b0, 1'b0, 3'd0, 0, 0, 0, 0);
        tick("b2b_idle");

        // Reset while holding an operation.
        drive(1'b1, 1'b0, 3'd6, 32'h99, 32'h11, 32'h8, 32'h500);
        tick("mid_cap");
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 0, 0, 0, 0);
        tick("mid_rst");
        chk("mid_rst_wb_const", PC_wb, 32'h4);
        rst_n = 1'b1;

        // Random traffic with occasional resets and boundary values.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r1, r2, im, pc;
            r1 = $urandom(); r2 = $urandom(); im = $urandom(); pc = $urandom();
            if ($urandom_range(0, 3) == 0) r2 = r1;
            if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) r1 = 32'h8000_0000;
            rst_n = ($urandom_range(0, 19) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  r1, r2, im, pc);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
